fifo_rr_arbiter: RTL and testbench

- Merges the read sides of NUM_SRC lookahead FIFOs into one lookahead output stream.
- Used where several producers share one consumer (e.g. a config or readback port).
- Round-robin arbitration with a bounded burst: the current owner keeps the grant for up to MAX_BURST consecutive words while other sources wait.
- Registered one-entry output stage; sustains 1 word/cycle.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 22 ++
 rtl/fifo_rr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_rr_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO round-robin merge arbiter.
package fifo_arb_pkg;
  localparam int STATS_W = 16;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  // Index width for n sources, never narrower than one bit
  function automatic int src_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// First-set search over req starting at index start, wrapping modulo N.
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = src_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);
  // Walk offsets from far to near so the nearest set bit after start wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N]) begin
        idx   = W'((int'(start) + i) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Merges NUM_SRC lookahead FIFO read ports into one lookahead stream with
// round-robin arbitration and a bounded burst per owner.
// Optional per-source grant counters: define FIFO_RR_ARBITER_STATS_EN.
module fifo_rr_arbiter import fifo_arb_pkg::*; #(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int SRC_W      = src_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            empty_i,
  output logic [NUM_SRC-1:0]            rd_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] dout_i,
  output logic                          empty,
  input  logic                          rd,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [SRC_W-1:0]              src
`ifdef FIFO_RR_ARBITER_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_SRC*STATS_W-1:0]    grant_cnt
`endif
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  arb_state_e         state;
  logic [SRC_W-1:0]   owner, start, pick_idx, grant;
  logic [BW-1:0]      burst_cnt;
  logic [NUM_SRC-1:0] owner_oh;
  logic               pick_found, others_ne, sticky, load;

  // Scan begins just past the last owner so it gets lowest priority
  assign start = (owner == SRC_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;

  rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .req   (~empty_i),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant selection and pop generation; pick_found doubles as "any source ready"
  always_comb begin
    owner_oh  = NUM_SRC'(1) << owner;
    others_ne = |(~empty_i & ~owner_oh);
    sticky    = (state == OWN) && !empty_i[owner] &&
                ((burst_cnt < BMAX) || !others_ne);
    grant     = sticky ? owner : pick_idx;
    load      = rst && (empty || rd) && pick_found;
    rd_i      = load ? (NUM_SRC'(1) << grant) : '0;
  end

  // Ownership / burst tracking FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (load) begin
      state <= OWN;
      if (state == IDLE || grant != owner) begin
        owner     <= grant;
        burst_cnt <= BW'(1);
      end else if (burst_cnt < BMAX) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end else if (state == OWN && !pick_found) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // One-entry output register: refill on load, otherwise drain on pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      empty <= 1'b1;
      dout  <= '0;
      src   <= '0;
    end else if (load) begin
      empty <= 1'b0;
      dout  <= dout_i[grant*DATA_WIDTH +: DATA_WIDTH];
      src   <= grant;
    end else if (rd && !empty) begin
      empty <= 1'b1;
    end
  end

`ifdef FIFO_RR_ARBITER_STATS_EN
  logic [NUM_SRC-1:0][STATS_W-1:0] cnt;
  assign grant_cnt = cnt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_stat
    // Saturating pop counter; a clear still records a same-cycle grant
    always_ff @(posedge clk) begin
      if (!rst)
        cnt[k] <= '0;
      else if (stats_clr)
        cnt[k] <= STATS_W'(rd_i[k]);
      else if (rd_i[k] && cnt[k] != '1)
        cnt[k] <= cnt[k] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed table-driven bench for fifo_rr_arbiter (NUM_SRC=4, MAX_BURST=4).
module tb_fifo_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   empty_i;
  logic [3:0]   rd_i;
  logic [127:0] dout_i;
  logic         empty;
  logic         rd;
  logic [31:0]  dout;
  logic [1:0]   src;
`ifdef FIFO_RR_ARBITER_STATS_EN
  logic         stats_clr;
  logic [63:0]  grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fifo_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .empty_i (empty_i),
    .rd_i    (rd_i),
    .dout_i  (dout_i),
    .empty   (empty),
    .rd      (rd),
    .dout    (dout),
    .src     (src)
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  emp;
    logic        rdv;
    logic [3:0]  rdi;
    logic        e;
    logic [1:0]  s;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] hd(input int k);
    return 32'h1111_1111 * (k + 1);
  endfunction

  task automatic add(input logic r, input logic [3:0] emp, input logic rdv,
                     input logic [3:0] rdi, input logic e, input logic [1:0] s,
                     input logic [31:0] d, input int n);
    vec_t v;
    v.r = r; v.emp = emp; v.rdv = rdv; v.rdi = rdi; v.e = e; v.s = s; v.d = d;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, return #1 after the next posedge
  task automatic step(input logic r, input logic [3:0] emp, input logic rdv);
    @(negedge clk);
    rst = r; empty_i = emp; rd = rdv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; empty_i = 4'hF; rd = 1'b0;
`ifdef FIFO_RR_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int k = 0; k < 4; k++) dout_i[k*32 +: 32] = hd(k);

    // reset held with all sources ready: no pops, stage empty
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 32'h0,  3);
    // release: IDLE scan from owner 0 + 1 picks source 1
    add(1, 4'b0000, 0, 4'b0010, 0, 1, hd(1),  1);
    // only src0 ready: owner 1 empty, scan wraps to 0
    add(1, 4'b1110, 1, 4'b0001, 0, 0, hd(0),  1);
    // src0 and src2 ready, constant pop: bursts of 4
    add(1, 4'b1010, 1, 4'b0001, 0, 0, hd(0),  3);
    add(1, 4'b1010, 1, 4'b0100, 0, 2, hd(2),  4);
    add(1, 4'b1010, 1, 4'b0001, 0, 0, hd(0),  1);
    // lone src3: ten consecutive grants, burst saturates
    add(1, 4'b0111, 1, 4'b1000, 0, 3, hd(3), 10);
    // src1 appears after saturation: scan wraps 3 -> 0 -> 1
    add(1, 4'b0101, 1, 4'b0010, 0, 1, hd(1),  1);
    // backpressure: stage held, no pops
    add(1, 4'b0101, 0, 4'b0000, 0, 1, hd(1),  5);
    // pop and refill in one cycle, stage stays full
    add(1, 4'b0101, 1, 4'b0010, 0, 1, hd(1),  1);
    // switch to src2 so it becomes owner
    add(1, 4'b1011, 1, 4'b0100, 0, 2, hd(2),  1);
    // drain: last word popped, everything empty
    add(1, 4'b1111, 1, 4'b0000, 1, 2, hd(2),  1);
    // pop while empty is ignored
    add(1, 4'b1111, 1, 4'b0000, 1, 2, hd(2),  1);
    // from IDLE with owner 2, src2 is the only candidate
    add(1, 4'b1011, 0, 4'b0100, 0, 2, hd(2),  1);
    // reset mid-operation drops the held word and pops nothing
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 32'h0,  1);
    add(1, 4'b0000, 0, 4'b0010, 0, 1, hd(1),  1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; empty_i = tbl[i].emp; rd = tbl[i].rdv;
      #1;
      chk($sformatf("v%0d rd_i", i), 32'(rd_i), 32'(tbl[i].rdi));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].e));
      chk($sformatf("v%0d src", i), 32'(src), 32'(tbl[i].s));
      chk($sformatf("v%0d dout", i), dout, tbl[i].d);
    end

`ifdef FIFO_RR_ARBITER_STATS_EN
    step(0, 4'hF, 0);
    step(0, 4'hF, 0);
    chk("stat reset c0", 32'(grant_cnt[15:0]), 32'd0);
    for (int i = 0; i < 7; i++) step(1, 4'b1110, 1);
    for (int i = 0; i < 3; i++) step(1, 4'b1101, 1);
    step(1, 4'hF, 1);
    chk("stat c0", 32'(grant_cnt[15:0]),  32'd7);
    chk("stat c1", 32'(grant_cnt[31:16]), 32'd3);
    chk("stat c2", 32'(grant_cnt[47:32]), 32'd0);
    chk("stat c3", 32'(grant_cnt[63:48]), 32'd0);
    @(negedge clk); stats_clr = 1'b1;
    step(1, 4'hF, 1);
    chk("clr c0", 32'(grant_cnt[15:0]),  32'd0);
    chk("clr c1", 32'(grant_cnt[31:16]), 32'd0);
    // clear with a same-cycle grant to src1 leaves a count of one
    step(1, 4'b1101, 1);
    chk("clr+grant c1", 32'(grant_cnt[31:16]), 32'd1);
    @(negedge clk); stats_clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
